// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types and sizes used by the move controller and its timer.
// AUTO_MOVE_EN adds the SCAN state used by the automatic timeout move.
package tictactoe_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned CELL_W    = 2;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned TIME_W    = 5;
  localparam int unsigned BOARD_W   = NUM_CELLS * CELL_W;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    CELL_X = 2'b01,
    CELL_O = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    WAIT,
    CHECK,
    WRITE,
    DONE,
    TIMEOUT,
    OVER
`ifdef AUTO_MOVE_EN
    , SCAN
`endif
  } mc_state_t;

  // Board write payload
  typedef struct packed {
    logic [IDX_W-1:0] addr;
    cell_t            data;
  } wr_req_t;

  function automatic cell_t symbol_for(logic turn_x);
    return turn_x ? CELL_X : CELL_O;
  endfunction

  function automatic logic [IDX_W-1:0] next_cell(logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_CELLS - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: a one-second prescaler feeding a seconds down-counter.
module turn_timer #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       reload,
  output logic [4:0] time_left,
  output logic       expire_c
);

  localparam int unsigned PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  logic [PRE_W-1:0] pre;
  logic             tick_c;

  assign tick_c   = run && (pre == PRE_W'(CLK_FREQ - 1));
  assign expire_c = tick_c && (time_left == 5'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre       <= '0;
      time_left <= 5'(TURN_SECONDS);
    end else if (reload) begin
      pre       <= '0;
      time_left <= 5'(TURN_SECONDS);
    end else if (tick_c) begin
      pre <= '0;
      if (time_left != 5'd0) time_left <= time_left - 1'b1;
    end else if (run) begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/move_controller.sv
// Cursor movement, cell validation, board write and per-turn timeout for tic-tac-toe.
// Define AUTO_MOVE_EN to make a timeout place the current symbol in the lowest empty cell.
module move_controller
  import tictactoe_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned TURN_SECONDS = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               turno,
  input  logic               btn_next,
  input  logic               btn_place,
  input  logic [BOARD_W-1:0] board_in,
  input  logic               game_over,
  output logic [IDX_W-1:0]   cursor,
  output logic               we,
  output logic [IDX_W-1:0]   wr_addr,
  output logic [CELL_W-1:0]  wr_data,
  output logic               jugado,
  output logic               timeout,
  output logic [TIME_W-1:0]  time_left
);

  mc_state_t        state, state_d;
  logic             next_q, place_q;
  logic             press_next_c, press_place_c;
  cell_t            cells [NUM_CELLS];
  logic [IDX_W-1:0] cursor_d;
  logic             we_d, jugado_d, timeout_d;
  wr_req_t          wr_q, wr_d;
  logic             timer_run_c, timer_reload_c, expire_c;
`ifdef AUTO_MOVE_EN
  logic [IDX_W-1:0] scan_q, scan_d;
  logic             auto_q, auto_d;
`endif

  assign press_next_c  = btn_next  && !next_q;
  assign press_place_c = btn_place && !place_q;

  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      cells[i] = cell_t'(board_in[CELL_W*i +: CELL_W]);
    end
  end

  // Timer only runs while idle in WAIT; a place press or game end freezes it that cycle
  assign timer_run_c    = (state == WAIT) && !game_over && !press_place_c;
  assign timer_reload_c = (state == DONE);

  turn_timer #(
    .CLK_FREQ    (CLK_FREQ),
    .TURN_SECONDS(TURN_SECONDS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (timer_run_c),
    .reload   (timer_reload_c),
    .time_left(time_left),
    .expire_c (expire_c)
  );

  assign wr_addr = wr_q.addr;
  assign wr_data = wr_q.data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT;
      next_q  <= 1'b0;
      place_q <= 1'b0;
      cursor  <= '0;
      we      <= 1'b0;
      wr_q    <= '0;
      jugado  <= 1'b0;
      timeout <= 1'b0;
`ifdef AUTO_MOVE_EN
      scan_q  <= '0;
      auto_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      next_q  <= btn_next;
      place_q <= btn_place;
      cursor  <= cursor_d;
      we      <= we_d;
      wr_q    <= wr_d;
      jugado  <= jugado_d;
      timeout <= timeout_d;
`ifdef AUTO_MOVE_EN
      scan_q  <= scan_d;
      auto_q  <= auto_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    cursor_d  = cursor;
    we_d      = 1'b0;
    wr_d      = wr_q;
    jugado_d  = 1'b0;
    timeout_d = 1'b0;
`ifdef AUTO_MOVE_EN
    scan_d    = scan_q;
    auto_d    = auto_q;
`endif
    case (state)
      WAIT: begin
        if (game_over) begin
          state_d = OVER;
        end else if (press_place_c) begin
          state_d = CHECK;
        end else begin
          if (press_next_c) cursor_d = next_cell(cursor);
          if (expire_c) state_d = TIMEOUT;
        end
      end
      CHECK: begin
        if (cells[cursor] == EMPTY) begin
          state_d = WRITE;
          we_d    = 1'b1;
          wr_d    = '{addr: cursor, data: symbol_for(turno)};
        end else begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        state_d  = DONE;
        jugado_d = 1'b1;
`ifdef AUTO_MOVE_EN
        timeout_d = auto_q;
`endif
      end
      DONE: begin
        state_d = WAIT;
`ifdef AUTO_MOVE_EN
        auto_d  = 1'b0;
`endif
      end
      TIMEOUT: begin
`ifdef AUTO_MOVE_EN
        state_d   = SCAN;
        scan_d    = '0;
        auto_d    = 1'b1;
`else
        state_d   = DONE;
        jugado_d  = 1'b1;
        timeout_d = 1'b1;
`endif
      end
`ifdef AUTO_MOVE_EN
      // One cell per cycle; full board skips the turn without writing
      SCAN: begin
        if (cells[scan_q] == EMPTY) begin
          state_d  = WRITE;
          we_d     = 1'b1;
          cursor_d = scan_q;
          wr_d     = '{addr: scan_q, data: symbol_for(turno)};
        end else if (scan_q == IDX_W'(NUM_CELLS - 1)) begin
          state_d   = DONE;
          jugado_d  = 1'b1;
          timeout_d = 1'b1;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
`endif
      OVER: state_d = OVER;
      default: state_d = WAIT;
    endcase
  end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Generates the `jugado` pulse consumed by the turn FSM.
- Moves the player's cursor over the 9 board cells and validates that the selected cell is empty.
- Writes X or O (per current turn) into the board register file.
- Runs a per-turn countdown; on expiry it forces a turn change.
- Sits between the debounced button inputs, the board storage and the turn FSM.

Parameters:
- CLK_FREQ, 50_000_000, clk cycles per one-second tick.
- TURN_SECONDS, 15, seconds allowed per turn (1..31).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- turno  in  1  current turn: 1 = X, 0 = O
- btn_next  in  1  synchronous debounced level; rising edge advances cursor
- btn_place  in  1  synchronous debounced level; rising edge requests placement at cursor
- board_in  in  18  cell i at [2i+1:2i]; 00 empty, 01 X, 10 O
- game_over  in  1  level; game finished
- cursor  out  4  selected cell 0..8
- we  out  1  board write strobe, one cycle
- wr_addr  out  4  cell written
- wr_data  out  2  01 when turno=1, 10 when turno=0
- jugado  out  1  one-cycle pulse; turn must change
- timeout  out  1  one-cycle pulse, coincident with a timeout-caused jugado
- time_left  out  5  seconds remaining in current turn

Behaviour:
- Reset (rst=0, async): state=WAIT, cursor=0, we=0, wr_addr=0, wr_data=0, jugado=0, timeout=0, time_left=TURN_SECONDS, prescaler=0, edge-detect registers=0.
- Edge detect: a press is a registered 0→1 transition of a button level. A held button produces one press only.
- WAIT:
  - Press on btn_next only: cursor increments; 8 wraps to 0.
  - Press on btn_place: go to CHECK next cycle. If btn_next and btn_place edges coincide, place wins and the cursor does not move.
  - Prescaler counts 0..CLK_FREQ-1. Its wrap is a tick, and each tick decrements time_left.
  - A tick taking time_left 1→0 goes to TIMEOUT. A place press in the same cycle wins over expiry.
  - game_over=1 in WAIT goes to OVER; it has priority over all other events.
- CHECK: cell[cursor]==00 goes to WRITE; otherwise returns to WAIT with no output change and the timer continuing.
- WRITE: we=1, wr_addr=cursor, wr_data from turno sampled this cycle. Go to DONE.
- DONE: jugado=1 for one cycle. Then WAIT, with time_left reloaded to TURN_SECONDS and the prescaler cleared.
- TIMEOUT: behaviour per Optional Feature. Ends in DONE-equivalent with jugado=1 and timeout=1 in the same cycle, then WAIT with reload.
- OVER: all strobes held 0, time_left frozen. Leaves only via reset.
- Timer behaviour outside WAIT: the timer does not run in CHECK/WRITE/DONE/TIMEOUT/OVER.
- Latency: place press edge to we = 2 cycles; to jugado = 3 cycles. turno toggles the cycle after jugado, before the next WAIT decision.
- Reset mid-write: we deasserts immediately (async). No partial jugado is emitted.

Optional Feature:
- Macro: AUTO_MOVE_EN.
- Defined:
  - TIMEOUT scans cells 0..8, one cell per cycle, for the lowest-index empty cell.
  - If found, it issues a WRITE of the current player's symbol there and sets cursor to that cell, then jugado+timeout.
  - If none is found (full board), it pulses jugado+timeout with no write.
- Undefined: TIMEOUT pulses jugado+timeout on the next cycle with no write (turn is skipped).

Decomposition:
- Shared package tictactoe_pkg:
  - cell_t (EMPTY=2'b00, CELL_X=2'b01, CELL_O=2'b10).
  - NUM_CELLS=9.
  - mc_state_t enum (WAIT, CHECK, WRITE, DONE, TIMEOUT, OVER; SCAN only under AUTO_MOVE_EN).
- Sub-module turn_timer:
  - Contents: prescaler plus time_left down-counter.
  - Inputs: run, reload.
  - Outputs: time_left, expire pulse.

Test Plan (CLK_FREQ=4, TURN_SECONDS=3 in sim):
- Reset, 3 btn_next presses → cursor=3. A held btn_next for 10 cycles → only +1. 9 presses from 0 → cursor=0.
- turno=1, cursor=4, board empty, place → we=1, wr_addr=4, wr_data=01 two cycles after the edge; jugado=1 on the next cycle; time_left reloads to 3.
- board_in cell 4 = 10, place at 4 → no we, no jugado, state back to WAIT, time_left keeps counting.
- No input for 12 cycles → time_left 3→2→1→0, timeout=jugado=1. With AUTO_MOVE_EN and cells 0,1 filled: we at wr_addr=2 first.
- Place edge in the same cycle as the final tick → normal write path, timeout never asserted.
- game_over=1 in WAIT → no further we/jugado on any button or tick. rst=0 mid-WRITE → we=0 immediately, all outputs at reset values.
